// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit.
// States, opcodes and datapath mux selects live here.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JALRADR  = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD  = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] MODE_ADD   = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_FUNCT = 2'b10;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation select from funct fields and controller mode.
// Address/branch phases force ADD or SUB regardless of funct.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  input  logic [1:0] alu_mode,
  output logic [3:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    if (alu_mode == MODE_SUB) begin
      ALUControl = ALU_SUB;
    end else if (alu_mode == MODE_FUNCT) begin
      case (funct3)
        3'b000:  ALUControl = (is_rtype && funct7b5)
                              ? ALU_SUB : ALU_ADD;
        3'b001:  ALUControl = ALU_SLL;
        3'b010:  ALUControl = ALU_SLT;
        3'b011:  ALUControl = ALU_SLTU;
        3'b100:  ALUControl = ALU_XOR;
        3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  ALUControl = ALU_OR;
        default: ALUControl = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RV32I datapath.
// Write enables are held low for as long as reset is high.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        Zero,
  input  logic        cout,
  input  logic        overflow,
  input  logic        sign,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        illegal,
  output logic [3:0]  state
);

  state_t     state_q;
  state_t     next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic [1:0] alu_mode;
  logic       ir_en, rw_en, mw_en, pc_en, ill;
  logic       taken;
  logic       unused;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign unused   = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= next;
  end

  always_comb begin
    next = S_FETCH;
    case (state_q)
      S_FETCH: next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:      next = S_EXECR;
          OP_I:      next = S_EXECI;
          OP_BRANCH: next = S_BRANCH;
          OP_JAL:    next = S_JUMP;
          OP_JALR:   next = S_JALRADR;
          OP_LUI:    next = S_LUI;
          OP_AUIPC:  next = S_AUIPC;
          default:   next = S_FETCH;
        endcase
      end
      S_MEMADR: next = (opcode == OP_LOAD)
                       ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: next = S_MEMWB;
      S_EXECR, S_EXECI, S_JUMP, S_AUIPC:
        next = S_ALUWB;
      S_JALRADR: next = S_JUMP;
      default: next = S_FETCH;
    endcase
  end

  // funct3 010/011 are not branches and never redirect
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = sign ^ overflow;
      3'b101:  taken = ~(sign ^ overflow);
      3'b110:  taken = ~cout;
      3'b111:  taken = cout;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ImmSrc    = IMM_I;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    AdrSrc    = 1'b0;
    alu_mode  = MODE_ADD;
    ir_en     = 1'b0;
    rw_en     = 1'b0;
    mw_en     = 1'b0;
    pc_en     = 1'b0;
    ill       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_en     = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        pc_en     = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
        ill     = ~is_legal(opcode);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rw_en     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw_en  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = SRCA_A;
        alu_mode = MODE_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA  = SRCA_A;
        ALUSrcB  = SRCB_IMM;
        alu_mode = MODE_FUNCT;
      end
      S_ALUWB: rw_en = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        alu_mode = MODE_SUB;
        pc_en    = taken;
      end
      S_JALRADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_JUMP: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        pc_en   = 1'b1;
      end
      S_LUI: begin
        ImmSrc    = IMM_U;
        ResultSrc = RES_IMM;
        rw_en     = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_U;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .is_rtype   (opcode == OP_R),
    .alu_mode   (alu_mode),
    .ALUControl (ALUControl)
  );

  assign IRWrite  = ir_en & ~reset;
  assign RegWrite = rw_en & ~reset;
  assign MemWrite = mw_en & ~reset;
  assign PCWrite  = pc_en & ~reset;
  assign illegal  = ill & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level model queues expected per-cycle
// controls, a negedge monitor pops and compares.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        Zero, cout, overflow, sign;
  logic [2:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic        AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal;
  logic [3:0]  state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .instr(instr),
    .Zero(Zero), .cout(cout), .overflow(overflow), .sign(sign),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .illegal(illegal),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [1:0] res, sa, sb;
    logic       adr, ir, rw, mw, pcw, ill;
    bit         rst;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(string tag, state_t s);
    exp_t e;
    e.tag = tag; e.st = s; e.imm = 3'b000; e.alu = 4'b0000;
    e.res = 2'b00; e.sa = 2'b00; e.sb = 2'b00;
    e.adr = 0; e.ir = 0; e.rw = 0; e.mw = 0; e.pcw = 0; e.ill = 0;
    e.rst = 0;
    return e;
  endfunction

  function automatic logic [3:0] alu_ref(logic [2:0] f3, logic f7,
                                         bit rtype);
    logic [3:0] tbl [8];
    tbl = '{4'b0000, 4'b0110, 4'b0101, 4'b1001,
            4'b0100, 4'b0111, 4'b0011, 4'b0010};
    if (f3 == 3'b000 && rtype && f7) return 4'b0001;
    if (f3 == 3'b101 && f7) return 4'b1000;
    return tbl[f3];
  endfunction

  function automatic bit br_ref(logic [2:0] f3, logic [31:0] a,
                                logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 0;
    endcase
  endfunction

  // Queue the expected cycles of one instruction; returns cycle count.
  function automatic int model(logic [31:0] ins, logic [31:0] a,
                               logic [31:0] b);
    logic [6:0] op;
    logic [2:0] f3;
    exp_t e;
    int n;
    op = ins[6:0]; f3 = ins[14:12];
    e = mk("fetch", S_FETCH);
    e.ir = 1; e.sb = 2'b10; e.res = 2'b10; e.pcw = 1;
    sb.push_back(e);
    e = mk("decode", S_DECODE);
    e.sa = 2'b01; e.sb = 2'b01;
    e.imm = (op == 7'b1101111) ? 3'b011 : 3'b010;
    e.ill = !(op inside {7'b0000011, 7'b0100011, 7'b0110011,
                         7'b0010011, 7'b1100011, 7'b1101111,
                         7'b1100111, 7'b0110111, 7'b0010111});
    sb.push_back(e);
    n = 2;
    case (op)
      7'b0000011: begin
        e = mk("memadr_lw", S_MEMADR); e.sa = 2'b10; e.sb = 2'b01;
        sb.push_back(e);
        e = mk("memread", S_MEMREAD); e.adr = 1; sb.push_back(e);
        e = mk("memwb", S_MEMWB); e.res = 2'b01; e.rw = 1;
        sb.push_back(e);
        n = 5;
      end
      7'b0100011: begin
        e = mk("memadr_sw", S_MEMADR); e.sa = 2'b10; e.sb = 2'b01;
        e.imm = 3'b001; sb.push_back(e);
        e = mk("memwrite", S_MEMWRITE); e.adr = 1; e.mw = 1;
        sb.push_back(e);
        n = 4;
      end
      7'b0110011, 7'b0010011: begin
        e = mk("exec", (op == 7'b0110011) ? S_EXECR : S_EXECI);
        e.sa = 2'b10;
        e.sb = (op == 7'b0110011) ? 2'b00 : 2'b01;
        e.alu = alu_ref(f3, ins[30], op == 7'b0110011);
        sb.push_back(e);
        e = mk("aluwb", S_ALUWB); e.rw = 1; sb.push_back(e);
        n = 4;
      end
      7'b1100011: begin
        e = mk("branch", S_BRANCH); e.sa = 2'b10; e.alu = 4'b0001;
        e.pcw = br_ref(f3, a, b); sb.push_back(e);
        n = 3;
      end
      7'b1101111, 7'b1100111: begin
        if (op == 7'b1100111) begin
          e = mk("jalradr", S_JALRADR); e.sa = 2'b10; e.sb = 2'b01;
          sb.push_back(e);
        end
        e = mk("jump", S_JUMP); e.sa = 2'b01; e.sb = 2'b10;
        e.pcw = 1; sb.push_back(e);
        e = mk("aluwb_j", S_ALUWB); e.rw = 1; sb.push_back(e);
        n = (op == 7'b1100111) ? 5 : 4;
      end
      7'b0110111: begin
        e = mk("lui", S_LUI); e.imm = 3'b100; e.res = 2'b11;
        e.rw = 1; sb.push_back(e);
        n = 3;
      end
      7'b0010111: begin
        e = mk("auipc", S_AUIPC); e.sa = 2'b01; e.sb = 2'b01;
        e.imm = 3'b100; sb.push_back(e);
        e = mk("aluwb_a", S_ALUWB); e.rw = 1; sb.push_back(e);
        n = 4;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic exp_t rst_exp(state_t s);
    exp_t e;
    e = mk("reset", s);
    e.rst = 1;
    return e;
  endfunction

  // Flags come from a genuine a-b subtraction.
  task automatic drive(logic [31:0] ins, logic [31:0] a,
                       logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    instr = ins;
    Zero = (d == 0);
    cout = (a >= b);
    sign = d[31];
    overflow = (a[31] != b[31]) && (d[31] != a[31]);
  endtask

  task automatic run(logic [31:0] ins, logic [31:0] a,
                     logic [31:0] b);
    int n;
    drive(ins, a, b);
    n = model(ins, a, b);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] en;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      en = {IRWrite, RegWrite, MemWrite, PCWrite, illegal};
      checks++;
      if (e.rst) begin
        if (en !== 5'b0 || state !== e.st) begin
          errors++;
          $display("FAIL %s: state=%0d en=%b, need state=%0d en=00000",
                   e.tag, state, en, e.st);
        end
      end else if ({state, ImmSrc, ALUControl, ResultSrc, ALUSrcA,
                    ALUSrcB, AdrSrc, en} !==
                   {e.st, e.imm, e.alu, e.res, e.sa, e.sb, e.adr,
                    e.ir, e.rw, e.mw, e.pcw, e.ill}) begin
        errors++;
        $display({"FAIL %s: got st=%0d imm=%b alu=%b res=%b sa=%b ",
                  "sb=%b adr=%b en=%b; need st=%0d imm=%b alu=%b ",
                  "res=%b sa=%b sb=%b adr=%b en=%b"},
                 e.tag, state, ImmSrc, ALUControl, ResultSrc, ALUSrcA,
                 ALUSrcB, AdrSrc, en, e.st, e.imm, e.alu, e.res, e.sa,
                 e.sb, e.adr, {e.ir, e.rw, e.mw, e.pcw, e.ill});
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] ops [9];
    int k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) begin
      w[6:0] = ops[k];
    end else begin
      for (int t = 0; t < 16; t++) begin
        w[6:0] = 7'($urandom);
        if (!is_legal(w[6:0])) break;
      end
      if (is_legal(w[6:0])) w[6:0] = 7'b0000000;
    end
    return w;
  endfunction

  initial begin
    logic [31:0] a, b;
    int n;
    reset = 1'b1;
    drive(32'h0000_0013, 0, 0);
    @(posedge clk); #1;
    sb.push_back(rst_exp(S_FETCH));
    sb.push_back(rst_exp(S_FETCH));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run(32'h0020_81b3, 5, 7);           // add x3,x1,x2
    run(32'h4020_81b3, 5, 7);           // sub
    run(32'h4020_d1b3, 5, 7);           // sra
    run(32'h0000_8063, 32'h44, 32'h44); // beq taken
    run(32'h0000_9063, 32'h44, 32'h44); // bne not taken
    run(32'h0000_a083, 1, 2);           // lw
    run(32'h0010_a023, 1, 2);           // sw
    run(32'h0000_80e7, 1, 2);           // jalr
    run(32'h0000_00ef, 1, 2);           // jal
    run(32'h0000_0000, 1, 2);           // illegal
    run(32'h1234_50b7, 1, 2);           // lui
    run(32'h1234_5097, 1, 2);           // auipc
    // reset while in MEMREAD
    drive(32'h0000_a083, 0, 0);
    n = model(32'h0000_a083, 0, 0);
    void'(sb.pop_back());
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.push_back(rst_exp(S_MEMREAD));
    @(posedge clk); #1;
    sb.push_back(rst_exp(S_FETCH));
    @(posedge clk); #1;
    reset = 1'b0;
    run(32'h0000_0013, 0, 0);
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
      run(rand_instr(), a, b);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, need 0",
               sb.size());
    end
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
